// File: rtl/mem_dump_streamer_pkg.sv
// Shared types and constants for the data-RAM dump streamer.
// The vector word width is shared with the processor top.
package mem_dump_streamer_pkg;

  localparam int unsigned VecWordW     = 48;
  localparam int unsigned BytesPerWord = VecWordW / 8;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StLoad,
    StSend,
    StNext,
    StDone
  } state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_dump_streamer_if.sv
// RAM read port and byte stream bundled for the dump streamer.
// master = streamer side, slave = RAM model / byte sink side.
interface mem_dump_streamer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = mem_dump_streamer_pkg::VecWordW
) ();

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rden;
  logic [DATA_W-1:0] ram_q;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output ram_addr,
    output ram_rden,
    input  ram_q,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  ram_addr,
    input  ram_rden,
    output ram_q,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/mem_dump_streamer_word_serializer.sv
// Loads one RAM word and emits it MSB byte first on a valid/ready stream.
// last_xfer_o flags the handshake that moves the final byte of the word.
module mem_dump_streamer_word_serializer
  import mem_dump_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = VecWordW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              tx_ready_i,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  output logic              last_xfer_o
);

  localparam int unsigned Bpw  = DATA_W / 8;
  localparam int unsigned IdxW = clog2_min1(Bpw);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              xfer;

  assign xfer        = valid_q & tx_ready_i;
  assign last_xfer_o = xfer && (idx_q == IdxW'(Bpw - 1));
  assign tx_valid_o  = valid_q;
  assign tx_data_o   = shift_q[DATA_W-1 -: 8];

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = data_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      shift_d = shift_q << 8;
      idx_d   = idx_q + 1'b1;
      if (last_xfer_o) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/mem_dump_streamer.sv
// Reads NUM_WORDS consecutive RAM words from BASE_ADDR and streams them
// out as bytes; the FSM sequences RAM reads and counts words.
module mem_dump_streamer
  import mem_dump_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = VecWordW,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  mem_dump_streamer_if.master  bus
);

  localparam int unsigned CntW  = clog2_min1(RD_LAT);
  localparam int unsigned WordW = clog2_min1(NUM_WORDS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, done_q, rden_q;
  logic              load;
  logic              last_xfer;

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_rden = rden_q;

  mem_dump_streamer_word_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk_i       (clk),
    .rst_ni      (rst),
    .load_i      (load),
    .data_i      (bus.ram_q),
    .tx_ready_i  (bus.tx_ready),
    .tx_valid_o  (bus.tx_valid),
    .tx_data_o   (bus.tx_data),
    .last_xfer_o (last_xfer)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          word_d  = '0;
          addr_d  = ADDR_W'(BASE_ADDR);
        end
      end
      StReq: begin
        if (RD_LAT <= 1) begin
          state_d = StLoad;
        end else begin
          cnt_d   = CntW'(RD_LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StLoad;
      end
      StLoad: begin
        load    = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (last_xfer) state_d = StNext;
      end
      StNext: begin
        if (word_q == WordW'(NUM_WORDS - 1)) begin
          state_d = StDone;
        end else begin
          word_d  = word_q + 1'b1;
          // Wraps modulo 2^ADDR_W by construction.
          addr_d  = addr_q + 1'b1;
          state_d = StReq;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rden_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      rden_q  <= (state_d == StReq) || (state_d == StWait);
    end
  end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: 16-word RAM window wrapping from 14,
// scoreboarded bytes and addresses, backpressure, restarts and mid-dump reset.
module tb_mem_dump_streamer;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 48;
  localparam int unsigned BASE = 14;
  localparam int unsigned NW   = 4;
  localparam int unsigned RL   = 2;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  mem_dump_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_dump_streamer #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BASE_ADDR (BASE),
    .NUM_WORDS (NW),
    .RD_LAT    (RL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: two-stage read pipeline, garbage when not enabled.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] pipe_q, q_q;
  always @(posedge clk) begin
    pipe_q <= bus.ram_rden ? mem[bus.ram_addr] : '0;
    q_q    <= pipe_q;
  end
  assign bus.ram_q = q_q;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_xfer   = 0;
  int n_done   = 0;
  int last_xfer_cyc = 0;

  logic [7:0]    byte_q [$];
  logic [AW-1:0] addr_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_expected();
    logic [AW-1:0] a;
    for (int w = 0; w < int'(NW); w++) begin
      a = AW'(int'(BASE) + w);
      addr_q.push_back(a);
      for (int b = 0; b < 6; b++) byte_q.push_back(mem[a][DW-1-8*b -: 8]);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: tx_ready held high. mode 1: toggling ready with a 7-cycle stall,
  // a start pulse mid-dump, and start held high once every byte has moved.
  task automatic run(input int mode, output int t_valid, output int t_done);
    int j;
    t_valid = -1;
    t_done  = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (t_valid < 0 && bus.tx_valid) t_valid = k;
      if (done) begin
        t_done = k;
        break;
      end
      @(posedge clk); #1;
      if (mode == 1) begin
        j = k + 1;
        bus.tx_ready = (j >= 14 && j <= 20) ? 1'b0 : j[0];
        start = (j == 9) || (n_xfer >= 24);
      end
    end
    check("done_seen", 64'(t_done > 0), 64'd1);
  endtask

  // Monitor: scoreboard pops, stall stability, address sequence, done timing.
  logic       prev_stall = 1'b0;
  logic       prev_rden  = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
      prev_rden  <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(bus.tx_valid), 64'd1);
        check("stall_data", 64'(bus.tx_data), 64'(prev_data));
      end
      if (bus.ram_rden && !prev_rden) begin
        check("addr_expected", 64'(addr_q.size() != 0), 64'd1);
        if (addr_q.size() != 0) check("ram_addr", 64'(bus.ram_addr), 64'(addr_q.pop_front()));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        check("byte_expected", 64'(byte_q.size() != 0), 64'd1);
        if (byte_q.size() != 0) check("tx_byte", 64'(bus.tx_data), 64'(byte_q.pop_front()));
        n_xfer++;
        last_xfer_cyc = cyc;
      end
      if (done) begin
        n_done++;
        check("done_with_busy", 64'(busy), 64'd1);
        check("done_after_last", 64'(cyc - last_xfer_cyc), 64'd2);
      end
      prev_stall <= bus.tx_valid & ~bus.tx_ready;
      prev_data  <= bus.tx_data;
      prev_rden  <= bus.ram_rden;
    end
  end

  int tv, td;

  initial begin
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 6; b++) mem[i][DW-1-8*b -: 8] = 8'(i * 16 + b + 1);
    mem[14] = 48'h0123_4567_89AB;
    bus.tx_ready = 1'b1;

    // Reset and idle
    #2 rst = 1'b0;
    #3;
    check("rst_ctrl", 64'({busy, done, bus.tx_valid, bus.ram_rden}), 64'd0);
    check("rst_addr", 64'(bus.ram_addr), 64'd0);
    check("rst_data", 64'(bus.tx_data), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("idle_ctrl", 64'({busy, done, bus.tx_valid, bus.ram_rden}), 64'd0);
    end

    // Dump 1: full speed, window wraps 14,15,0,1
    push_expected();
    n_xfer = 0; n_done = 0;
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    run(0, tv, td);
    check("d1_first_valid", 64'(tv), 64'd4);
    check("d1_done_cycle", 64'(td), 64'd41);
    @(posedge clk); #1;
    check("d1_xfers", 64'(n_xfer), 64'd24);
    check("d1_dones", 64'(n_done), 64'd1);
    check("d1_bytes_left", 64'(byte_q.size()), 64'd0);
    check("d1_addrs_left", 64'(addr_q.size()), 64'd0);

    // Dump 2: backpressure, starts while busy and during done
    repeat (3) @(posedge clk);
    push_expected();
    n_xfer = 0; n_done = 0;
    pulse_start();
    run(1, tv, td);
    check("d2_start_on_done", 64'(start), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("d2_idle_after_done", 64'(busy), 64'd0);
    check("d2_xfers", 64'(n_xfer), 64'd24);
    check("d2_dones", 64'(n_done), 64'd1);
    check("d2_bytes_left", 64'(byte_q.size()), 64'd0);
    bus.tx_ready = 1'b1;
    push_expected();
    n_xfer = 0; n_done = 0;
    // Start held through the idle cycle following done: accepted here.
    @(posedge clk); #1 start = 1'b0;

    // Dump 3: back-to-back dump after done
    run(0, tv, td);
    check("d3_first_valid", 64'(tv), 64'd4);
    check("d3_done_cycle", 64'(td), 64'd41);
    @(posedge clk); #1;
    check("d3_xfers", 64'(n_xfer), 64'd24);
    check("d3_bytes_left", 64'(byte_q.size()), 64'd0);

    // Dump 4: reset during 3rd byte of word 2
    repeat (2) @(posedge clk);
    push_expected();
    n_xfer = 0; n_done = 0;
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      if (n_xfer == 8) break;
      @(posedge clk); #1;
    end
    check("d4_reached_byte8", 64'(n_xfer), 64'd8);
    check("d4_valid_byte8", 64'(bus.tx_valid), 64'd1);
    check("d4_data_byte8", 64'(bus.tx_data), 64'(byte_q[0]));
    #2 rst = 1'b0;
    #1;
    check("d4_rst_ctrl", 64'({busy, done, bus.tx_valid, bus.ram_rden}), 64'd0);
    check("d4_rst_addr", 64'(bus.ram_addr), 64'd0);
    check("d4_rst_data", 64'(bus.tx_data), 64'd0);
    byte_q.delete();
    addr_q.delete();
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("d4_idle_ctrl", 64'({busy, done, bus.tx_valid, bus.ram_rden}), 64'd0);
    end

    // Dump 5: fresh dump from base after abort
    push_expected();
    n_xfer = 0; n_done = 0;
    pulse_start();
    run(0, tv, td);
    check("d5_first_valid", 64'(tv), 64'd4);
    check("d5_done_cycle", 64'(td), 64'd41);
    @(posedge clk); #1;
    check("d5_xfers", 64'(n_xfer), 64'd24);
    check("d5_dones", 64'(n_done), 64'd1);
    check("d5_bytes_left", 64'(byte_q.size()), 64'd0);
    check("d5_addrs_left", 64'(addr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_dump_streamer.md
Name: mem_dump_streamer

Overview:
- Downstream consumer of the vector processor's data RAM; after a program finishes, it reads a contiguous window of 48-bit data words and serializes them as bytes on a valid/ready byte stream (UART TX / host link).
- Owns a dedicated read port (second RAM port or muxed port, owned while busy).
- Sits beside the processor top.

Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 48, RAM word width; must be a multiple of 8.
- BASE_ADDR, 0, first word address dumped.
- NUM_WORDS, 256, number of words dumped per start; must be ≥1.
- RD_LAT, 2, cycles from ram_addr/ram_rden presented to ram_q valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a dump; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte transfers.
- ram_addr  out  ADDR_W  word address to data RAM.
- ram_rden  out  1  read enable, high only in REQ/WAIT.
- ram_q  in  DATA_W  RAM read data.
- tx_data  out  8  byte to sink.
- tx_valid  out  1  byte available.
- tx_ready  in  1  sink accepts; a transfer happens on a rising edge with tx_valid&tx_ready.

Behaviour:
- Reset (rst=0, async): state IDLE, busy=0, done=0, ram_rden=0, ram_addr=0, tx_valid=0, tx_data=0, word and byte counters 0. Reset mid-dump aborts immediately. No partial resume. A byte presented but not accepted is dropped.
- States:
  - IDLE: start=1 → REQ. Load word_idx=0 and ram_addr=BASE_ADDR.
  - REQ: assert ram_rden, load wait counter=RD_LAT-1 → WAIT. If RD_LAT=1, go straight to LOAD.
  - WAIT: hold ram_addr and ram_rden. Decrement the counter. At 0 → LOAD.
  - LOAD: capture ram_q into shift register, byte_idx=0, ram_rden=0 → SEND.
  - SEND: tx_valid=1, tx_data = shift_reg[DATA_W-1 -: 8] (MSB byte first). On a transfer: shift left 8 and increment byte_idx. At byte_idx = DATA_W/8-1, the transfer leaves SEND → NEXT.
  - NEXT: tx_valid=0. If word_idx=NUM_WORDS-1 → DONE. Else word_idx+1, ram_addr+1 → REQ.
  - DONE: done=1 for one cycle, busy=0 on exit → IDLE.
- Address arithmetic is modulo 2^ADDR_W. BASE_ADDR+NUM_WORDS exceeding 2^ADDR_W wraps to 0 silently.
- tx_data/tx_valid must stay stable while tx_valid=1 and tx_ready=0. tx_valid never drops without a transfer, except on reset.
- tx_ready may be high outside SEND; it has no effect there.
- start coincident with done (DONE state): ignored. A new start is accepted only in IDLE.
- Latency:
  - Per word: 1 (REQ) + RD_LAT-1 (WAIT) + 1 (LOAD) + 6 transfers + 1 (NEXT).
  - With tx_ready held 1 and RD_LAT=2: 10 cycles per word. First tx_valid is 4 cycles after the start edge.
- busy is high in every state except IDLE. done is never high with busy low in the same state.

Decomposition:
- Shared package: state enum (IDLE, REQ, WAIT, LOAD, SEND, NEXT, DONE), constant BYTES_PER_WORD = DATA_W/8, and the vector word width (48), shared with the processor.
- One natural sub-module, word_serializer: parallel load, shift-left-by-8, byte counter, valid/ready handshake, last-byte flag. The top FSM owns the RAM sequencing and word counting.

Test Plan:
- Reset/idle: rst=0 then 1, no start → busy=0, done=0, tx_valid=0, ram_rden=0 for 50 cycles.
- Single word: NUM_WORDS=1, BASE_ADDR=5, RAM[5]=48'h0123_4567_89AB, tx_ready=1 → bytes 01,23,45,67,89,AB on consecutive cycles. done pulses 2 cycles after the last byte. ram_addr=5 throughout.
- Backpressure: same setup, tx_ready toggling 1010… and held 0 for 7 cycles mid-word → tx_data stable while stalled, no duplicate or lost bytes, 6 transfers total.
- Multi-word wrap: ADDR_W=4, BASE_ADDR=14, NUM_WORDS=4 → addresses read 14, 15, 0, 1; 24 bytes in order; exactly one done.
- Start during busy and at done: extra start pulses mid-dump and on the done cycle → ignored. A start one cycle after done → second full dump.
- Reset mid-operation: assert rst during the 3rd byte of word 2 → all outputs 0 asynchronously. After release, a new start dumps from BASE_ADDR again.
